// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory test sequencer: the fixed script,
// step-op encoding and FSM state codes.
package mem_test_pkg;

  localparam int NUM_STEPS  = 10;
  localparam int STEP_IDX_W = 4;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } step_op_e;

  typedef struct packed {
    step_op_e    op;
    logic [15:0] addr;
    logic [15:0] data;
  } step_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Script constants are 16 bits wide; the sequencer resizes them to the bus.
  function automatic step_t script_step(input logic [STEP_IDX_W-1:0] idx);
    step_t s;
    case (idx)
      4'd0:    s = '{OP_WRITE, 16'd1,   16'h003A};
      4'd1:    s = '{OP_WRITE, 16'd512, 16'h0010};
      4'd2:    s = '{OP_READ,  16'd1,   16'h003A};
      4'd3:    s = '{OP_READ,  16'd512, 16'h0010};
      4'd4:    s = '{OP_WRITE, 16'd1,   16'h00A0};
      4'd5:    s = '{OP_WRITE, 16'd512, 16'h0020};
      4'd6:    s = '{OP_READ,  16'd1,   16'h00A0};
      4'd7:    s = '{OP_READ,  16'd512, 16'h0020};
      4'd8:    s = '{OP_READ,  16'd20,  16'h0042};
      4'd9:    s = '{OP_READ,  16'd21,  16'h0037};
      default: s = '{OP_READ,  16'd0,   16'h0000};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// single-cycle pulse for every accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // A new level is taken on its DEBOUNCE_CYCLES-th consecutive differing cycle.
  assign accept  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
  assign pulse_o = pulse_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      pulse_q <= accept & sync2_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_test_sequencer.sv
// Walks a fixed write/read script against a 1-cycle-latency RAM port,
// one step per button press or continuously under auto_run.
module mem_test_sequencer
  import mem_test_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_button,
  input  logic                  auto_run,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_d,
  output logic                  mem_we,
  output logic [3:0]            step_index,
  output logic [DATA_WIDTH-1:0] last_rd,
  output logic                  done,
  output logic                  pass,
  output logic [3:0]            fail_step
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_STEPS - 1);

  logic [2:0]            state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] last_rd_q, last_rd_d;
  logic                  pass_q, pass_d;
  logic [3:0]            fail_q, fail_d;

  logic                  step_pulse;
  step_t                 cur;
  logic [ADDR_WIDTH-1:0] step_addr;
  logic [DATA_WIDTH-1:0] step_data;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .button_i (step_button),
    .pulse_o  (step_pulse)
  );

  assign cur       = script_step(idx_q);
  assign step_addr = ADDR_WIDTH'(cur.addr);
  assign step_data = DATA_WIDTH'(cur.data);

  // Port drive is decoded from state so a reset mid-step drops mem_we at once.
  always_comb begin
    mem_addr = '0;
    mem_d    = '0;
    mem_we   = 1'b0;
    if (state_q == ST_ISSUE || state_q == ST_LATCH) begin
      mem_addr = step_addr;
    end
    if (state_q == ST_ISSUE && cur.op == OP_WRITE) begin
      mem_we = 1'b1;
      mem_d  = step_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_rd_d = last_rd_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    case (state_q)
      ST_IDLE:  state_d = ST_WAIT;
      ST_WAIT:  if (step_pulse || auto_run) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_LATCH;
      ST_LATCH: begin
        if (cur.op == OP_READ) begin
          last_rd_d = mem_q;
          if (mem_q != step_data) begin
            pass_d = 1'b0;
            // Only the first mismatch is recorded.
            if (pass_q) fail_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_rd_q <= '0;
      pass_q    <= 1'b1;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_rd_q <= last_rd_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign step_index = idx_q;
  assign last_rd    = last_rd_q;
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign fail_step  = fail_q;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Directed bench for mem_test_sequencer with a 1-cycle-latency RAM model.
module tb_mem_test_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_button = 1'b0;
  logic        auto_run = 1'b0;
  logic [15:0] mem_q;
  logic [11:0] mem_addr;
  logic [15:0] mem_d;
  logic        mem_we;
  logic [3:0]  step_index;
  logic [15:0] last_rd;
  logic        done;
  logic        pass;
  logic [3:0]  fail_step;

  logic        preload = 1'b1;
  logic        corrupt_en = 1'b0;
  logic [15:0] ram [0:4095];

  int n_assert = 0;
  int n_fail   = 0;

  mem_test_sequencer #(
    .ADDR_WIDTH      (12),
    .DATA_WIDTH      (16),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .step_button (step_button),
    .auto_run    (auto_run),
    .mem_q       (mem_q),
    .mem_addr    (mem_addr),
    .mem_d       (mem_d),
    .mem_we      (mem_we),
    .step_index  (step_index),
    .last_rd     (last_rd),
    .done        (done),
    .pass        (pass),
    .fail_step   (fail_step)
  );

  always #5 clk = ~clk;

  // RAM model; corrupt_en makes every read of address 512 return 0011.
  always @(posedge clk) begin
    if (preload) begin
      ram[1]   <= 16'h0000;
      ram[512] <= 16'h0000;
      ram[20]  <= 16'h0042;
      ram[21]  <= 16'h0037;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_d;
    end
    mem_q <= (corrupt_en && mem_addr == 12'd512) ? 16'h0011 : ram[mem_addr];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int n);
    step_button = 1'b1;
    tick(n);
    step_button = 1'b0;
    tick(12);
  endtask

  initial begin
    // Reset values
    tick(3);
    chk("rst_idx", step_index, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_d", mem_d, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_last_rd", last_rd, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 1);
    chk("rst_fail_step", fail_step, 0);

    // Auto run of the full script
    preload  = 1'b0;
    auto_run = 1'b1;
    reset    = 1'b0;
    tick(1);
    chk("a_wait_we", mem_we, 0);
    chk("a_wait_addr", mem_addr, 0);
    tick(1);
    chk("a_issue0_we", mem_we, 1);
    chk("a_issue0_addr", mem_addr, 1);
    chk("a_issue0_d", mem_d, 16'h003A);
    chk("a_issue0_idx", step_index, 0);
    tick(1);
    chk("a_latch0_we", mem_we, 0);
    chk("a_latch0_addr", mem_addr, 1);
    chk("a_latch0_d", mem_d, 0);
    tick(7);
    chk("a_step2_last_rd", last_rd, 16'h003A);
    chk("a_step2_idx", step_index, 3);
    tick(20);
    chk("a_pre_done", done, 0);
    chk("a_pre_done_idx", step_index, 9);
    tick(1);
    chk("a_done", done, 1);
    chk("a_pass", pass, 1);
    chk("a_last_rd", last_rd, 16'h0037);
    chk("a_fail_step", fail_step, 0);
    chk("a_ram1", ram[1], 16'h00A0);
    chk("a_ram512", ram[512], 16'h0020);

    // Button presses while DONE are ignored
    press(20);
    chk("d_btn_idx", step_index, 9);
    chk("d_btn_done", done, 1);
    chk("d_btn_addr", mem_addr, 0);

    // Corrupted read data at 512
    reset      = 1'b1;
    preload    = 1'b1;
    corrupt_en = 1'b1;
    tick(3);
    preload = 1'b0;
    reset   = 1'b0;
    tick(12);
    chk("c_pass_before", pass, 1);
    tick(1);
    chk("c_pass_after3", pass, 0);
    chk("c_fail_step3", fail_step, 3);
    chk("c_last_rd3", last_rd, 16'h0011);
    chk("c_idx4", step_index, 4);
    tick(18);
    chk("c_done", done, 1);
    chk("c_pass_end", pass, 0);
    chk("c_fail_step_end", fail_step, 3);
    chk("c_last_rd_end", last_rd, 16'h0037);
    corrupt_en = 1'b0;

    // Reset during ISSUE of write step 4
    reset   = 1'b1;
    preload = 1'b1;
    tick(3);
    preload = 1'b0;
    reset   = 1'b0;
    tick(14);
    chk("r_issue4_we", mem_we, 1);
    chk("r_issue4_addr", mem_addr, 1);
    chk("r_issue4_d", mem_d, 16'h00A0);
    chk("r_issue4_idx", step_index, 4);
    reset    = 1'b1;
    auto_run = 1'b0;
    #1;
    chk("r_async_we", mem_we, 0);
    chk("r_async_addr", mem_addr, 0);
    chk("r_async_d", mem_d, 0);
    chk("r_async_idx", step_index, 0);
    chk("r_async_pass", pass, 1);
    chk("r_async_last_rd", last_rd, 0);
    chk("r_async_done", done, 0);
    tick(2);
    chk("r_ram1_kept", ram[1], 16'h003A);

    // Button-stepped run
    preload = 1'b1;
    tick(1);
    preload = 1'b0;
    reset   = 1'b0;
    tick(5);
    chk("b_start_idx", step_index, 0);
    chk("b_start_we", mem_we, 0);
    press(20);
    chk("b_press1_idx", step_index, 1);
    press(20);
    chk("b_press2_idx", step_index, 2);
    press(3);
    chk("b_glitch1_idx", step_index, 2);
    press(3);
    chk("b_glitch2_idx", step_index, 2);
    press(20);
    chk("b_press3_idx", step_index, 3);
    chk("b_press3_last_rd", last_rd, 16'h003A);

    // Pulse timed to land while the step launched by auto_run is in LATCH
    step_button = 1'b1;
    tick(4);
    auto_run = 1'b1;
    tick(1);
    auto_run = 1'b0;
    chk("l_issue_addr", mem_addr, 512);
    chk("l_issue_we", mem_we, 0);
    tick(19);
    step_button = 1'b0;
    tick(12);
    chk("l_idx", step_index, 4);
    chk("l_last_rd", last_rd, 16'h0010);
    chk("l_pass", pass, 1);
    chk("l_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
